// File: rtl/memoria_dados_latencia.sv
// memoria_dados_latencia
// Data-memory responder for the load/store path. Each request is captured
// and answered after LATENCY clock edges. Misaligned or out-of-range accesses
// complete with erro=1 and do not touch the memory. This models slow memory
// so the processor's stall logic gets exercised.

module memoria_dados_latencia #(
    parameter int DEPTH   = 256,  // number of 64-bit words, power of two, >= 2
    parameter int LATENCY = 3     // edges from acceptance to completion, >= 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        WeDM,
    input  logic [63:0] doutULA,
    input  logic [63:0] dinDM,
    output logic [63:0] doutDM,
    output logic        pronto,
    output logic        erro,
    output logic        ocupado
);

    // Word-index width and wait-counter width. The counter only has to hold
    // LATENCY-1, but it keeps at least one bit so LATENCY=1 still elaborates.
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
    localparam logic [60:0]   WORD_LIM = 61'(DEPTH);

    typedef enum logic {
        OCIOSO = 1'b0,
        ESPERA = 1'b1
    } estado_t;

    estado_t       estado;
    estado_t       estado_prox;
    logic [CW-1:0] contador;
    logic [CW-1:0] contador_prox;

    // Control strobes produced by the next-state logic.
    logic          aceita;
    logic          conclui;

    // Request fields captured at acceptance. Later changes on the inputs are
    // irrelevant to an in-flight transaction.
    logic          cap_we;
    logic [63:0]   cap_addr;
    logic [63:0]   cap_dado;

    // Address decode of the captured request.
    logic          falha;
    logic [AW-1:0] indice;
    logic          escreve;

    logic [63:0]   mem [DEPTH];

    // Next-state logic: accept in OCIOSO, count down in ESPERA, complete at zero.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement leaves one unassigned (no latch).
        estado_prox   = estado;
        contador_prox = contador;
        aceita        = 1'b0;
        conclui       = 1'b0;

        case (estado)
            OCIOSO: begin
                if (req) begin
                    aceita        = 1'b1;
                    contador_prox = CNT_INIT;
                    estado_prox   = ESPERA;
                end
            end
            ESPERA: begin
                if (contador != '0) begin
                    contador_prox = contador - 1'b1;
                end else begin
                    conclui     = 1'b1;
                    estado_prox = OCIOSO;
                end
            end
            default: begin
                estado_prox = OCIOSO;
            end
        endcase
    end

    // State and wait-counter registers. Reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the values from before the edge.
        if (reset) begin
            estado   <= OCIOSO;
            contador <= '0;
        end else begin
            estado   <= estado_prox;
            contador <= contador_prox;
        end
    end

    // Capture the request fields on acceptance. These are pure datapath
    // registers and are only read after a later acceptance, so they need no reset.
    always_ff @(posedge clk) begin
        if (aceita) begin
            cap_we   <= WeDM;
            cap_addr <= doutULA;
            cap_dado <= dinDM;
        end
    end

    // Fault when the byte offset is non-zero or the word number is past the array.
    assign falha   = (cap_addr[2:0] != 3'b000) || (cap_addr[63:3] >= WORD_LIM);
    assign indice  = cap_addr[3 +: AW];
    assign escreve = conclui && cap_we && !falha;
    assign ocupado = (estado == ESPERA);

    // Completion: registered pronto/erro pulses, load data, and the store write.
    // The store sits in the non-reset branch, so an edge that sees reset high
    // never writes, even if it would have been the completing edge.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the memory array is deliberately left out of the reset branch.
        // Its contents survive reset, and clearing it would turn the array
        // into DEPTH*64 resettable flops.
        if (reset) begin
            pronto <= 1'b0;
            erro   <= 1'b0;
            doutDM <= '0;
        end else begin
            pronto <= conclui;
            erro   <= conclui && falha;
            if (conclui) begin
                if (falha) begin
                    doutDM <= '0;
                end else if (!cap_we) begin
                    doutDM <= mem[indice];
                end
            end
            if (escreve) begin
                mem[indice] <= cap_dado;
            end
        end
    end

endmodule

// File: tb/tb_memoria_dados_latencia.sv
// Self-checking bench for memoria_dados_latencia. It runs a directed vector
// table, hand-written multi-cycle sequences (back-to-back requests, resets
// mid-flight) and randomized traffic, all checked against a word-array model.
// A second instance with LATENCY=1 and DEPTH=4 covers the minimum-latency case.

module tb_memoria_dados_latencia;

    localparam int DEPTH   = 256;
    localparam int LATENCY = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        WeDM;
    logic [63:0] doutULA;
    logic [63:0] dinDM;
    logic [63:0] doutDM;
    logic        pronto;
    logic        erro;
    logic        ocupado;

    // Signals for the minimum-latency instance.
    logic        req1;
    logic        we1;
    logic [63:0] addr1;
    logic [63:0] din1;
    logic [63:0] dout1;
    logic        pronto1;
    logic        erro1;
    logic        ocupado1;

    always #5 clk = ~clk;

    memoria_dados_latencia #(.DEPTH(DEPTH), .LATENCY(LATENCY)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .WeDM    (WeDM),
        .doutULA (doutULA),
        .dinDM   (dinDM),
        .doutDM  (doutDM),
        .pronto  (pronto),
        .erro    (erro),
        .ocupado (ocupado)
    );

    memoria_dados_latencia #(.DEPTH(4), .LATENCY(1)) u_dut1 (
        .clk     (clk),
        .reset   (reset),
        .req     (req1),
        .WeDM    (we1),
        .doutULA (addr1),
        .dinDM   (din1),
        .doutDM  (dout1),
        .pronto  (pronto1),
        .erro    (erro1),
        .ocupado (ocupado1)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: one word per address, plus the last value shown on doutDM.
    logic [63:0] model_mem [DEPTH];
    logic [63:0] model_dout = '0;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] data;
        logic        exp_erro;
        logic [63:0] exp_dout;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [63:0] preload_val(input int i);
        return {32'hA5A5_5A5A, 32'(i)};
    endfunction

    // Applies one transaction to the model and returns what the DUT must show.
    task automatic model_apply(input logic we, input logic [63:0] addr, input logic [63:0] data,
                               output logic exp_erro, output logic [63:0] exp_dout);
        logic [63:0] word;
        word = addr / 8;
        if ((addr % 8 != 0) || (word >= 64'(DEPTH))) begin
            exp_erro   = 1'b1;
            model_dout = '0;
        end else begin
            exp_erro = 1'b0;
            if (we) model_mem[word] = data;
            else    model_dout      = model_mem[word];
        end
        exp_dout = model_dout;
    endtask

    // Drives one request, scrambles the inputs while it is in flight and
    // checks the busy window, the completion cycle and the cycle after it.
    task automatic run_txn(input logic we, input logic [63:0] addr, input logic [63:0] data,
                           input logic exp_erro, input logic [63:0] exp_dout, input string tag);
        @(negedge clk);
        req     = 1'b1;
        WeDM    = we;
        doutULA = addr;
        dinDM   = data;
        @(posedge clk);
        #1;
        check({tag, ".ocupado_e0"}, 64'(ocupado), 64'd1);
        check({tag, ".pronto_e0"}, 64'(pronto), 64'd0);
        req     = 1'($urandom);
        WeDM    = 1'($urandom);
        doutULA = {$urandom, $urandom};
        dinDM   = {$urandom, $urandom};
        for (int k = 1; k < LATENCY; k++) begin
            @(posedge clk);
            #1;
            check({tag, ".ocupado_wait"}, 64'(ocupado), 64'd1);
            check({tag, ".pronto_wait"}, 64'(pronto), 64'd0);
            req     = 1'($urandom);
            doutULA = {$urandom, $urandom};
        end
        @(posedge clk);
        #1;
        req = 1'b0;
        check({tag, ".pronto"}, 64'(pronto), 64'd1);
        check({tag, ".ocupado_done"}, 64'(ocupado), 64'd0);
        check({tag, ".erro"}, 64'(erro), 64'(exp_erro));
        check({tag, ".doutDM"}, doutDM, exp_dout);
        @(posedge clk);
        #1;
        check({tag, ".pronto_after"}, 64'(pronto), 64'd0);
        check({tag, ".erro_after"}, 64'(erro), 64'd0);
    endtask

    // Same idea for the LATENCY=1 instance: accept at E0, complete at E1.
    task automatic run_txn1(input logic we, input logic [63:0] addr, input logic [63:0] data,
                            input logic exp_erro, input logic [63:0] exp_dout, input string tag);
        @(negedge clk);
        req1  = 1'b1;
        we1   = we;
        addr1 = addr;
        din1  = data;
        @(posedge clk);
        #1;
        check({tag, ".ocupado_e0"}, 64'(ocupado1), 64'd1);
        check({tag, ".pronto_e0"}, 64'(pronto1), 64'd0);
        req1  = 1'b0;
        addr1 = {$urandom, $urandom};
        @(posedge clk);
        #1;
        check({tag, ".pronto"}, 64'(pronto1), 64'd1);
        check({tag, ".erro"}, 64'(erro1), 64'(exp_erro));
        check({tag, ".doutDM"}, dout1, exp_dout);
        check({tag, ".ocupado_done"}, 64'(ocupado1), 64'd0);
        @(posedge clk);
        #1;
        check({tag, ".pronto_after"}, 64'(pronto1), 64'd0);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, ".pronto"}, 64'(pronto), 64'd0);
        check({tag, ".erro"}, 64'(erro), 64'd0);
        check({tag, ".ocupado"}, 64'(ocupado), 64'd0);
        check({tag, ".doutDM"}, doutDM, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        e_erro;
        logic [63:0] e_dout;
        logic [63:0] addr;
        logic        we;
        logic [63:0] data;
        int          r;

        reset   = 1'b1;
        req     = 1'b0;
        WeDM    = 1'b0;
        doutULA = '0;
        dinDM   = '0;
        req1    = 1'b0;
        we1     = 1'b0;
        addr1   = '0;
        din1    = '0;

        // Reset values of the main instance.
        #7;
        check_idle_zero("por");
        #15;
        reset = 1'b0;

        // Minimum latency on the small instance (DEPTH=4, word 3 is the last).
        run_txn1(1'b1, 64'h18, 64'hCAFE, 1'b0, 64'h0, "l1_store");
        run_txn1(1'b0, 64'h18, 64'h0, 1'b0, 64'hCAFE, "l1_load");
        run_txn1(1'b0, 64'h20, 64'h0, 1'b1, 64'h0, "l1_oor");
        run_txn1(1'b0, 64'h1C, 64'h0, 1'b1, 64'h0, "l1_misal");

        // Preload every word with stores only, so doutDM stays 0 throughout.
        for (int i = 0; i < DEPTH; i++) begin
            model_apply(1'b1, 64'(i) * 8, preload_val(i), e_erro, e_dout);
            run_txn(1'b1, 64'(i) * 8, preload_val(i), e_erro, e_dout, "preload");
        end

        // Directed vector table with hand-derived expectations.
        tbl[0] = '{1'b1, 64'h40,  64'h0123_4567_89AB_CDEF, 1'b0, 64'h0};
        tbl[1] = '{1'b0, 64'h40,  64'h0,                   1'b0, 64'h0123_4567_89AB_CDEF};
        tbl[2] = '{1'b1, 64'h44,  64'hFFFF,                1'b1, 64'h0};
        tbl[3] = '{1'b0, 64'h40,  64'h0,                   1'b0, 64'h0123_4567_89AB_CDEF};
        tbl[4] = '{1'b0, 64'h800, 64'h0,                   1'b1, 64'h0};
        tbl[5] = '{1'b1, 64'h48,  64'hDEAD,                1'b0, 64'h0};
        tbl[6] = '{1'b0, 64'h7F8, 64'h0,                   1'b0, preload_val(255)};
        tbl[7] = '{1'b0, 64'h803, 64'h0,                   1'b1, 64'h0};
        tbl[8] = '{1'b0, 64'h48,  64'h0,                   1'b0, 64'hDEAD};
        for (int i = 0; i < 9; i++) begin
            model_apply(tbl[i].we, tbl[i].addr, tbl[i].data, e_erro, e_dout);
            run_txn(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].exp_erro, tbl[i].exp_dout,
                    $sformatf("tbl%0d", i));
        end

        // Reset asserted between edges while a store is waiting: every output
        // clears at once and the store is lost.
        @(negedge clk);
        req     = 1'b1;
        WeDM    = 1'b1;
        doutULA = 64'h50;
        dinDM   = 64'h1234;
        @(posedge clk);
        #1;
        req = 1'b0;
        check("rstmid.ocupado_e0", 64'(ocupado), 64'd1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_idle_zero("rstmid.async");
        @(posedge clk);
        #2;
        reset      = 1'b0;
        model_dout = '0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_idle_zero("rstmid.hold");
        end
        model_apply(1'b0, 64'h50, 64'h0, e_erro, e_dout);
        run_txn(1'b0, 64'h50, 64'h0, e_erro, e_dout, "rstmid.load");

        // With req held high, a load completes every LATENCY+1 cycles and the
        // address change during the wait is ignored.
        model_apply(1'b1, 64'h00, 64'h11, e_erro, e_dout);
        run_txn(1'b1, 64'h00, 64'h11, e_erro, e_dout, "b2b.pre0");
        model_apply(1'b1, 64'h08, 64'h22, e_erro, e_dout);
        run_txn(1'b1, 64'h08, 64'h22, e_erro, e_dout, "b2b.pre1");
        @(negedge clk);
        req     = 1'b1;
        WeDM    = 1'b0;
        doutULA = 64'h00;
        @(posedge clk);
        #1;
        doutULA = 64'h08;
        check("b2b.ocupado_a", 64'(ocupado), 64'd1);
        for (int k = 1; k < LATENCY; k++) begin
            @(posedge clk);
            #1;
            check("b2b.pronto_wait_a", 64'(pronto), 64'd0);
        end
        model_apply(1'b0, 64'h00, 64'h0, e_erro, e_dout);
        @(posedge clk);
        #1;
        check("b2b.pronto_a", 64'(pronto), 64'd1);
        check("b2b.dout_a", doutDM, e_dout);
        check("b2b.ocupado_gap", 64'(ocupado), 64'd0);
        @(posedge clk);
        #1;
        check("b2b.ocupado_b", 64'(ocupado), 64'd1);
        check("b2b.pronto_b0", 64'(pronto), 64'd0);
        check("b2b.dout_held", doutDM, e_dout);
        for (int k = 1; k < LATENCY; k++) begin
            @(posedge clk);
            #1;
            check("b2b.pronto_wait_b", 64'(pronto), 64'd0);
        end
        model_apply(1'b0, 64'h08, 64'h0, e_erro, e_dout);
        @(posedge clk);
        #1;
        req = 1'b0;
        check("b2b.pronto_b", 64'(pronto), 64'd1);
        check("b2b.dout_b", doutDM, e_dout);
        @(posedge clk);
        #1;
        check("b2b.pronto_end", 64'(pronto), 64'd0);
        check("b2b.ocupado_end", 64'(ocupado), 64'd0);

        // Reset one cycle after accepting a store: no pronto, no write.
        model_apply(1'b1, 64'h80, 64'h55, e_erro, e_dout);
        run_txn(1'b1, 64'h80, 64'h55, e_erro, e_dout, "abort.pre");
        @(negedge clk);
        req     = 1'b1;
        WeDM    = 1'b1;
        doutULA = 64'h80;
        dinDM   = 64'hAA;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset      = 1'b0;
        model_dout = '0;
        for (int k = 0; k < LATENCY + 2; k++) begin
            @(posedge clk);
            #1;
            check("abort.no_pronto", 64'(pronto), 64'd0);
        end
        model_apply(1'b0, 64'h80, 64'h0, e_erro, e_dout);
        run_txn(1'b0, 64'h80, 64'h0, e_erro, e_dout, "abort.load");

        // Reset held high across the completing edge of a store.
        @(negedge clk);
        req     = 1'b1;
        WeDM    = 1'b1;
        doutULA = 64'h80;
        dinDM   = 64'h77;
        @(posedge clk);
        #1;
        req = 1'b0;
        for (int k = 1; k < LATENCY; k++) @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rstedge.pronto", 64'(pronto), 64'd0);
        check("rstedge.ocupado", 64'(ocupado), 64'd0);
        #2;
        reset      = 1'b0;
        model_dout = '0;
        @(posedge clk);
        #1;
        check("rstedge.pronto_after", 64'(pronto), 64'd0);
        model_apply(1'b0, 64'h80, 64'h0, e_erro, e_dout);
        run_txn(1'b0, 64'h80, 64'h0, e_erro, e_dout, "rstedge.load");

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            r    = $urandom_range(0, 9);
            we   = 1'($urandom);
            data = {$urandom, $urandom};
            if (r < 7)       addr = 64'($urandom_range(0, DEPTH - 1)) * 8;
            else if (r == 7) addr = 64'($urandom_range(0, DEPTH - 1)) * 8 + 64'($urandom_range(1, 7));
            else if (r == 8) addr = (64'(DEPTH) + 64'($urandom_range(0, 1000))) * 8;
            else             addr = {$urandom, $urandom};
            model_apply(we, addr, data, e_erro, e_dout);
            run_txn(we, addr, data, e_erro, e_dout, $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
